// File: rtl/auto_player_pkg.sv
// Shared constants, types and song contents for the auto player.
package auto_player_pkg;

    // Global mode code and octave codes shared with the rest of the instrument
    localparam logic [2:0] MODE_AUTO  = 3'b011;
    localparam logic [1:0] OCT_NORMAL = 2'b00;
    localparam logic [1:0] LOW_NOTE   = 2'b01;
    localparam logic [1:0] HIGH_NOTE  = 2'b10;

    // Entry layout {note[7:5], octave[4:3], beats[2:0]}
    localparam int NOTE_W    = 3;
    localparam int OCT_W     = 2;
    localparam int BEATS_W   = 3;
    localparam int NUM_SONGS = 4;
    localparam int SONG_W    = 2;
    localparam int IDX_MAX_W = 5;
    localparam int CNT_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PLAY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [NOTE_W-1:0]  note;
        logic [OCT_W-1:0]   octave;
        logic [BEATS_W-1:0] beats;
    } entry_t;

    function automatic entry_t mk_entry(input logic [NOTE_W-1:0] n,
                                        input logic [OCT_W-1:0] o,
                                        input logic [BEATS_W-1:0] b);
        mk_entry = '{note: n, octave: o, beats: b};
    endfunction

    // Song table; any entry not listed reads as all-zero, i.e. the end marker
    function automatic entry_t song_entry(input logic [SONG_W-1:0] song,
                                          input logic [IDX_MAX_W-1:0] idx);
        song_entry = '0;
        case ({song, idx})
            {2'd0, 5'd0}: song_entry = mk_entry(3'd3, OCT_NORMAL, 3'd2);
            {2'd1, 5'd0}: song_entry = mk_entry(3'd5, HIGH_NOTE,  3'd1);
            {2'd1, 5'd1}: song_entry = mk_entry(3'd0, OCT_NORMAL, 3'd1);
            {2'd1, 5'd2}: song_entry = mk_entry(3'd1, LOW_NOTE,   3'd2);
            {2'd2, 5'd0}: song_entry = mk_entry(3'd1, OCT_NORMAL, 3'd1);
            {2'd2, 5'd1}: song_entry = mk_entry(3'd2, LOW_NOTE,   3'd1);
            {2'd2, 5'd2}: song_entry = mk_entry(3'd6, HIGH_NOTE,  3'd2);
            {2'd2, 5'd3}: song_entry = mk_entry(3'd7, OCT_NORMAL, 3'd1);
            {2'd3, 5'd0}: song_entry = mk_entry(3'd4, OCT_NORMAL, 3'd3);
            {2'd3, 5'd1}: song_entry = mk_entry(3'd2, HIGH_NOTE,  3'd2);
            default:      song_entry = '0;
        endcase
    endfunction

endpackage

// File: rtl/auto_song_rom.sv
// Song storage: registered read, one cycle from address to entry.
module auto_song_rom
    import auto_player_pkg::*;
#(
    parameter int IDX_W = 5
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [SONG_W-1:0] i_song,
    input  logic [IDX_W-1:0]  i_index,
    output entry_t            o_entry
);

    logic [IDX_MAX_W-1:0] w_idx;
    entry_t               r_entry;

    // Widen the entry index to the table's full index width
    always_comb begin
        w_idx              = '0;
        w_idx[IDX_W-1:0]   = i_index;
    end

    // Registered table lookup
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_entry <= '0;
        else       r_entry <= song_entry(i_song, w_idx);
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/auto_player.sv
// Automatic song player: steps through a ROM song, timing each note and gap.
module auto_player
    import auto_player_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = CLK_HZ / 4,
    parameter int GAP_CYCLES  = CLK_HZ / 40,
    parameter int SONG_LEN    = 32
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mode,
    input  logic        start,
    input  logic        pause,
    input  logic [1:0]  song_sel,
    output logic [2:0]  auto_note,
    output logic [1:0]  auto_octave,
    output logic [4:0]  note_index,
    output logic        playing,
    output logic        song_done
);

    localparam int               IDX_W    = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SONG_LEN - 1);
    localparam logic [CNT_W-1:0] BEAT_LEN = CNT_W'(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);

    state_t             r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic [IDX_W-1:0]   r_index,  w_index_nxt;
    logic [SONG_W-1:0]  r_song,   w_song_nxt;
    logic [NOTE_W-1:0]  r_note,   w_note_nxt;
    logic [OCT_W-1:0]   r_oct,    w_oct_nxt;
    logic               r_hold,   w_hold_nxt;
    logic               w_done_nxt;
    logic [NOTE_W-1:0]  r_auto_note, w_auto_note_nxt;
    logic [OCT_W-1:0]   r_auto_oct,  w_auto_oct_nxt;
    logic               r_playing,   w_playing_nxt;
    logic               r_song_done;
    logic [4:0]         w_index_out;
    entry_t             w_rom;

    // ROM is addressed with the next song/index so the entry is ready in FETCH
    auto_song_rom #(.IDX_W(IDX_W)) u_rom (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_song  (w_song_nxt),
        .i_index (w_index_nxt),
        .o_entry (w_rom)
    );

    // Next-state logic; mode-off beats start, start beats everything else
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_index_nxt = r_index;
        w_song_nxt  = r_song;
        w_note_nxt  = r_note;
        w_oct_nxt   = r_oct;
        w_done_nxt  = 1'b0;
        if (mode != MODE_AUTO) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_index_nxt = '0;
        end else if (start) begin
            w_state_nxt = ST_FETCH;
            w_cnt_nxt   = '0;
            w_index_nxt = '0;
            w_song_nxt  = song_sel;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_nxt   = '0;
                    w_index_nxt = '0;
                end
                ST_FETCH: begin
                    if (w_rom.beats == '0) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                        w_index_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = ST_PLAY;
                        w_note_nxt  = w_rom.note;
                        w_oct_nxt   = w_rom.octave;
                        w_cnt_nxt   = CNT_W'(w_rom.beats) * BEAT_LEN;
                    end
                end
                ST_PLAY: begin
                    if (!r_hold) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            w_state_nxt = ST_GAP;
                            w_cnt_nxt   = GAP_LEN;
                        end else begin
                            w_cnt_nxt   = r_cnt - CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (!r_hold) begin
                        if (r_cnt <= CNT_W'(1)) begin
                            w_cnt_nxt = '0;
                            if (r_index == LAST_IDX) begin
                                w_state_nxt = ST_IDLE;
                                w_done_nxt  = 1'b1;
                                w_index_nxt = '0;
                            end else begin
                                w_state_nxt = ST_FETCH;
                                w_index_nxt = r_index + IDX_W'(1);
                            end
                        end else begin
                            w_cnt_nxt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_index_nxt = '0;
                end
            endcase
        end
    end

    // Output decode from the next state; a paused cycle is muted and frozen together
    always_comb begin
        w_hold_nxt      = pause && ((w_state_nxt == ST_PLAY) || (w_state_nxt == ST_GAP));
        w_auto_note_nxt = '0;
        w_auto_oct_nxt  = '0;
        if (w_state_nxt == ST_PLAY) begin
            w_auto_oct_nxt = w_oct_nxt;
            if (!w_hold_nxt) w_auto_note_nxt = w_note_nxt;
        end
        w_playing_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_index     <= '0;
            r_song      <= '0;
            r_note      <= '0;
            r_oct       <= '0;
            r_hold      <= 1'b0;
            r_auto_note <= '0;
            r_auto_oct  <= '0;
            r_playing   <= 1'b0;
            r_song_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_index     <= w_index_nxt;
            r_song      <= w_song_nxt;
            r_note      <= w_note_nxt;
            r_oct       <= w_oct_nxt;
            r_hold      <= w_hold_nxt;
            r_auto_note <= w_auto_note_nxt;
            r_auto_oct  <= w_auto_oct_nxt;
            r_playing   <= w_playing_nxt;
            r_song_done <= w_done_nxt;
        end
    end

    // Present the entry index at the fixed 5-bit port width
    always_comb begin
        w_index_out            = '0;
        w_index_out[IDX_W-1:0] = r_index;
    end

    assign auto_note   = r_auto_note;
    assign auto_octave = r_auto_oct;
    assign note_index  = w_index_out;
    assign playing     = r_playing;
    assign song_done   = r_song_done;

endmodule
